key_evt_ctrl: RTL and testbench

Front-panel controller placed after the 3-key debouncer. It takes the debounced active-low key levels and classifies each press as short, long or auto-repeat. It arbitrates between simultaneous keys: one owner key at a time, and multi-key chords are rejected. Resulting actions drive the settings registers (mode, value) that configure the measurement datapath, with an update strobe for downstream consumers.

---
 rtl/key_ui_pkg.sv | 11 +
 rtl/key_cfg_regs.sv | 48 ++++
 rtl/key_evt_ctrl.sv | 98 +++++++++
 tb/tb_key_evt_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ui_pkg.sv
// key_ui_pkg: shared FSM states, event kinds and key indices for the front-panel controller
package key_ui_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, HOLD, WAIT_REL} state_t;
  typedef enum logic [1:0] {SHORT, LONG, REP} evt_kind_t;
  localparam int K_MODE = 0;
  localparam int K_UP = 1;
  localparam int K_DN = 2;
  function automatic logic [1:0] first_key(input logic [2:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/key_cfg_regs.sv
// key_cfg_regs: mode/value settings registers driven by key events, with change strobe
module key_cfg_regs
  import key_ui_pkg::*;
#(
  parameter int MODE_NUM = 4,
  parameter int VAL_W = 8,
  parameter int VAL_MAX = 255,
  parameter int VAL_INIT = 0,
  localparam int MODE_W = $clog2(MODE_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        evt_short,
  input  logic [2:0]        evt_long,
  input  logic [2:0]        evt_rep,
  output logic [MODE_W-1:0] mode,
  output logic [VAL_W-1:0]  value,
  output logic              cfg_upd
);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);
  localparam logic [VAL_W:0] VMAX = (VAL_W + 1)'(VAL_MAX);
  localparam logic [VAL_W-1:0] VINIT = VAL_W'(VAL_INIT);
  logic [2:0] any_evt;
  logic [VAL_W:0] inc;
  logic [MODE_W-1:0] mode_nxt;
  logic [VAL_W-1:0] val_nxt;
  always_comb begin
    any_evt = evt_short | evt_long | evt_rep;
    inc = {1'b0, value} + 1'b1;
    mode_nxt = !any_evt[K_MODE] ? mode :
               evt_short[K_MODE] ? (mode == MODE_LAST ? '0 : mode + 1'b1) :
               evt_long[K_MODE] ? '0 : mode;
    val_nxt = (any_evt[K_MODE] && evt_long[K_MODE]) ? VINIT :
              any_evt[K_UP] ? (inc > VMAX ? value : inc[VAL_W-1:0]) :
              any_evt[K_DN] ? (value == '0 ? value : value - 1'b1) : value;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= '0;
      value <= VINIT;
      cfg_upd <= 1'b0;
    end else begin
      mode <= mode_nxt;
      value <= val_nxt;
      cfg_upd <= (mode_nxt != mode) || (val_nxt != value);
    end
  end
endmodule

// File: rtl/key_evt_ctrl.sv
// key_evt_ctrl: classifies debounced key presses into short/long/repeat events and drives settings
module key_evt_ctrl
  import key_ui_pkg::*;
#(
  parameter int LONG_CYC = 25_000_000,
  parameter int REP_CYC = 5_000_000,
  parameter int MODE_NUM = 4,
  parameter int VAL_W = 8,
  parameter int VAL_MAX = 255,
  parameter int VAL_INIT = 0,
  localparam int MODE_W = $clog2(MODE_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        key_n,
  output logic [2:0]        evt_short,
  output logic [2:0]        evt_long,
  output logic [2:0]        evt_rep,
  output logic [MODE_W-1:0] mode,
  output logic [VAL_W-1:0]  value,
  output logic              cfg_upd,
  output logic              busy
);
  localparam int CNT_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_END = CNT_W'(REP_CYC - 1);
  state_t state, nxt;
  evt_kind_t kind;
  logic [1:0] owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0] act, own_oh;
  logic held, fire;
  assign act = ~key_n;
  assign own_oh = 3'b001 << owner;
  assign held = act == own_oh;
  always_ff @(posedge clk) state <= rst ? WAIT_REL : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = act == '0 ? IDLE : $onehot(act) ? PRESS : WAIT_REL;
      PRESS:   nxt = held ? (cnt == LONG_END ? HOLD : PRESS) : act == '0 ? IDLE : WAIT_REL;
      HOLD:    nxt = held ? HOLD : act == '0 ? IDLE : WAIT_REL;
      default: nxt = act == '0 ? IDLE : WAIT_REL;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    fire = 1'b0;
    kind = SHORT;
    cnt_nxt = '0;
    owner_nxt = owner;
    case (state)
      IDLE: owner_nxt = $onehot(act) ? first_key(act) : owner;
      PRESS: begin
        fire = held ? cnt == LONG_END : act == '0;
        kind = held ? LONG : SHORT;
        cnt_nxt = (held && cnt != LONG_END) ? cnt + 1'b1 : '0;
      end
      HOLD: begin
        fire = held && cnt == REP_END;
        kind = REP;
        cnt_nxt = (held && cnt != REP_END) ? cnt + 1'b1 : '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      owner <= '0;
      evt_short <= '0;
      evt_long <= '0;
      evt_rep <= '0;
    end else begin
      cnt <= cnt_nxt;
      owner <= owner_nxt;
      evt_short <= (fire && kind == SHORT) ? own_oh : '0;
      evt_long <= (fire && kind == LONG) ? own_oh : '0;
      evt_rep <= (fire && kind == REP) ? own_oh : '0;
    end
  end
  key_cfg_regs #(
    .MODE_NUM(MODE_NUM),
    .VAL_W(VAL_W),
    .VAL_MAX(VAL_MAX),
    .VAL_INIT(VAL_INIT)
  ) u_cfg (
    .clk(clk),
    .rst(rst),
    .evt_short(evt_short),
    .evt_long(evt_long),
    .evt_rep(evt_rep),
    .mode(mode),
    .value(value),
    .cfg_upd(cfg_upd)
  );
endmodule

// File: tb/tb_key_evt_ctrl.sv
// tb_key_evt_ctrl: scoreboard bench for key event classification and settings registers
module tb_key_evt_ctrl;
  localparam int LONG = 8;
  localparam int REP = 4;
  localparam int MN = 4;
  localparam int VMAX = 10;
  localparam int VINIT = 5;
  typedef struct {
    int kind;
    int key;
    int mode;
    int val;
    bit upd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] key_n = 3'b111;
  logic [2:0] evt_short, evt_long, evt_rep;
  logic [1:0] mode;
  logic [7:0] value;
  logic cfg_upd, busy;
  exp_t q[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int m_val = VINIT;
  bit pend = 0;
  int obs_kind, obs_key;
  logic [2:0] ev;
  key_evt_ctrl #(
    .LONG_CYC(LONG),
    .REP_CYC(REP),
    .MODE_NUM(MN),
    .VAL_W(8),
    .VAL_MAX(VMAX),
    .VAL_INIT(VINIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .evt_short(evt_short),
    .evt_long(evt_long),
    .evt_rep(evt_rep),
    .mode(mode),
    .value(value),
    .cfg_upd(cfg_upd),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        checks++;
        if (mode !== 2'(cur.mode)) begin errors++; $display("FAIL cfg_mode got %0d exp %0d", mode, cur.mode); end
        checks++;
        if (value !== 8'(cur.val)) begin errors++; $display("FAIL cfg_value got %0d exp %0d", value, cur.val); end
        checks++;
        if (cfg_upd !== cur.upd) begin errors++; $display("FAIL cfg_upd got %b exp %b", cfg_upd, cur.upd); end
        pend = 0;
      end else begin
        checks++;
        if (cfg_upd !== 1'b0) begin errors++; $display("FAIL spurious_cfg_upd got %b exp 0", cfg_upd); end
      end
      ev = evt_short | evt_long | evt_rep;
      if (ev !== 3'b000) begin
        checks++;
        if ($countones({evt_short, evt_long, evt_rep}) != 1) begin
          errors++;
          $display("FAIL evt_onehot got s=%b l=%b r=%b exp one bit", evt_short, evt_long, evt_rep);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_evt got s=%b l=%b r=%b exp none", evt_short, evt_long, evt_rep);
        end else begin
          cur = q.pop_front();
          obs_kind = (|evt_short) ? 0 : (|evt_long) ? 1 : 2;
          obs_key = ev[0] ? 0 : ev[1] ? 1 : 2;
          checks++;
          if (obs_kind != cur.kind) begin errors++; $display("FAIL evt_kind got %0d exp %0d", obs_kind, cur.kind); end
          checks++;
          if (obs_key != cur.key) begin errors++; $display("FAIL evt_key got %0d exp %0d", obs_key, cur.key); end
          pend = 1;
        end
      end
    end
  end
  task automatic push_evt(input int kind, input int key);
    exp_t e;
    int nm, nv;
    nm = m_mode;
    nv = m_val;
    if (key == 0) begin
      if (kind == 0) nm = (m_mode == MN - 1) ? 0 : m_mode + 1;
      else if (kind == 1) begin nm = 0; nv = VINIT; end
    end else if (key == 1) begin
      nv = (m_val < VMAX) ? m_val + 1 : m_val;
    end else begin
      nv = (m_val > 0) ? m_val - 1 : 0;
    end
    e.kind = kind;
    e.key = key;
    e.mode = nm;
    e.val = nv;
    e.upd = (nm != m_mode) || (nv != m_val);
    q.push_back(e);
    m_mode = nm;
    m_val = nv;
  endtask
  task automatic press(input int key, input int h);
    if (h <= LONG) begin
      push_evt(0, key);
    end else begin
      push_evt(1, key);
      for (int i = 0; i < (h - LONG - 1) / REP; i++) push_evt(2, key);
    end
    key_n = ~(3'b001 << key);
    repeat (h) @(negedge clk);
    key_n = 3'b111;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    key_n = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if ({evt_short, evt_long, evt_rep} !== 9'b0) begin errors++; $display("FAIL reset_evt got %b exp 0", {evt_short, evt_long, evt_rep}); end
    checks++;
    if (cfg_upd !== 1'b0) begin errors++; $display("FAIL reset_cfg_upd got %b exp 0", cfg_upd); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
    checks++;
    if (value !== 8'(VINIT)) begin errors++; $display("FAIL reset_value got %0d exp %0d", value, VINIT); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask
  task automatic test_short_mode;
    for (int i = 0; i < 4; i++) press(0, 3);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL short_mode_wrap got %0d exp 0", mode); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL short_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_long_repeat;
    press(1, 20);
    checks++;
    if (value !== 8'd8) begin errors++; $display("FAIL long_rep_value got %0d exp 8", value); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL long_rep_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_saturate;
    press(1, LONG + 1 + 4 * REP);
    checks++;
    if (value !== 8'(VMAX)) begin errors++; $display("FAIL sat_value got %0d exp %0d", value, VMAX); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL sat_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_chord;
    key_n = 3'b011;
    repeat (2) @(negedge clk);
    key_n = 3'b001;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL chord_busy_both got %b exp 1", busy); end
    key_n = 3'b011;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL chord_busy_one got %b exp 1", busy); end
    key_n = 3'b111;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL chord_busy_rel got %b exp 0", busy); end
    press(2, 3);
    checks++;
    if (value !== 8'(VMAX - 1)) begin errors++; $display("FAIL chord_dec_value got %0d exp %0d", value, VMAX - 1); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL chord_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_held_reset;
    rst = 1'b1;
    key_n = 3'b100;
    m_mode = 0;
    m_val = VINIT;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL held_rst_busy got %b exp 1", busy); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL held_rst_mode got %0d exp 0", mode); end
    checks++;
    if (value !== 8'(VINIT)) begin errors++; $display("FAIL held_rst_value got %0d exp %0d", value, VINIT); end
    key_n = 3'b111;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_rst_rel_busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL held_rst_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_long_mode;
    press(0, 1);
    press(0, 1);
    for (int i = 0; i < 4; i++) press(1, 3);
    checks++;
    if (mode !== 2'd2 || value !== 8'd9) begin errors++; $display("FAIL pre_long_cfg got %0d/%0d exp 2/9", mode, value); end
    press(0, 10);
    checks++;
    if (mode !== 2'd0 || value !== 8'(VINIT)) begin errors++; $display("FAIL long_mode_cfg got %0d/%0d exp 0/%0d", mode, value, VINIT); end
    press(0, 3);
    press(1, 3);
    key_n = 3'b110;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    m_mode = 0;
    m_val = VINIT;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got %b exp 1", busy); end
    checks++;
    if (mode !== 2'd0 || value !== 8'(VINIT)) begin errors++; $display("FAIL mid_rst_cfg got %0d/%0d exp 0/%0d", mode, value, VINIT); end
    key_n = 3'b111;
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL long_mode_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  task automatic test_back_to_back;
    press(1, 2);
    press(2, 2);
    press(2, 2);
    checks++;
    if (value !== 8'(VINIT - 1)) begin errors++; $display("FAIL b2b_value got %0d exp %0d", value, VINIT - 1); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d exp 0", q.size()); q.delete(); end
  endtask
  initial begin
    test_reset;
    test_short_mode;
    test_long_repeat;
    test_saturate;
    test_chord;
    test_held_reset;
    test_long_mode;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
